sram_32b_responder: RTL and testbench

- Responder side of the LSU data-memory handshake. Accepts 32-bit word read/write requests with a byte mask and carries each one out as two 16-bit accesses on an external IS61WV25616 asynchronous SRAM.
- Returns read data with a one-cycle `ack` pulse. Sits between the LSU data-memory port and the board SRAM pins.

---
 rtl/sram_32b_responder_if.sv | 12 +
 rtl/sram_32b_responder.sv | 132 +++++++++++++
 tb/tb_sram_32b_responder.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/sram_32b_responder_if.sv
// sram_32b_responder_if: LSU data-memory handshake between the load/store unit and the SRAM responder.
interface sram_32b_responder_if #(parameter int ADDR_W = 13);
  logic [ADDR_W-1:0] addr;
  logic [31:0]       w_data;
  logic [3:0]        bmask;
  logic              wr_en;
  logic              rd_en;
  logic [31:0]       r_data;
  logic              ack;
  modport master (output addr, w_data, bmask, wr_en, rd_en, input r_data, ack);
  modport slave  (input addr, w_data, bmask, wr_en, rd_en, output r_data, ack);
endinterface

// File: rtl/sram_32b_responder.sv
// sram_32b_responder: 32-bit word requests carried out as two 16-bit phases on an IS61WV25616 async SRAM.
// Define SRAM_HALF_SKIP_EN to skip write phases whose byte-mask half is all zero.
module sram_32b_responder #(
  parameter int ADDR_W    = 13,
  parameter int PHASE_CYC = 2
) (
  input  logic                clk,
  input  logic                rst,
  sram_32b_responder_if.slave bus,
  output logic [17:0]         SRAM_ADDR,
  inout  wire  [15:0]         SRAM_DQ,
  output logic                SRAM_CE_N,
  output logic                SRAM_WE_N,
  output logic                SRAM_OE_N,
  output logic                SRAM_LB_N,
  output logic                SRAM_UB_N
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD_LO = 3'd1;
  localparam logic [2:0] RD_HI = 3'd2;
  localparam logic [2:0] WR_LO = 3'd3;
  localparam logic [2:0] WR_HI = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;
  localparam int CW = PHASE_CYC > 1 ? $clog2(PHASE_CYC) : 1;
  logic [2:0]        state_q, state_d, wr_first, wr_second;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-3:0] word_q, word_d;
  logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
  logic [15:0]       lo_q, lo_d, dq_q, dq_d;
  logic [3:0]        bmask_q, bmask_d;
  logic [17:0]       sa_q, sa_d;
  logic              ack_q, ce_q, ce_d, we_q, we_d, oe_q, oe_d, lb_q, lb_d, ub_q, ub_d, dq_oe_q;
  logic              last, last_d, rd_ph, wr_ph, hi;
  logic [1:0]        m;
  logic              unused_addr;
  assign unused_addr = &{1'b0, bus.addr[1:0]};
`ifdef SRAM_HALF_SKIP_EN
  assign wr_first  = |bus.bmask[1:0] ? WR_LO : |bus.bmask[3:2] ? WR_HI : DONE;
  assign wr_second = |bmask_q[3:2] ? WR_HI : DONE;
`else
  assign wr_first  = WR_LO;
  assign wr_second = WR_HI;
`endif
  assign last = cnt_q == CW'(PHASE_CYC - 1);
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    bmask_d = bmask_q;
    rdata_d = rdata_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: if (bus.wr_en || bus.rd_en) begin
        state_d = bus.wr_en ? wr_first : RD_LO;
        word_d  = bus.addr[ADDR_W-1:2];
        wdata_d = bus.w_data;
        bmask_d = bus.bmask;
      end
      RD_LO: if (last) begin
        state_d = RD_HI;
        lo_d    = SRAM_DQ;
      end
      RD_HI: if (last) begin
        state_d = DONE;
        rdata_d = {SRAM_DQ, lo_q};
      end
      WR_LO:   state_d = last ? wr_second : WR_LO;
      WR_HI:   state_d = last ? DONE : WR_HI;
      default: state_d = IDLE;
    endcase
    cnt_d = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + 1'b1;
  end
  // Pins are decoded from next state and registered, so they change only on the clock edge.
  assign rd_ph  = state_d == RD_LO || state_d == RD_HI;
  assign wr_ph  = state_d == WR_LO || state_d == WR_HI;
  assign hi     = state_d == RD_HI || state_d == WR_HI;
  assign last_d = cnt_d == CW'(PHASE_CYC - 1);
  assign m      = hi ? bmask_d[3:2] : bmask_d[1:0];
  assign ce_d   = ~(rd_ph | wr_ph);
  assign oe_d   = ~rd_ph;
  assign we_d   = ~(wr_ph & ~last_d);
  assign lb_d   = ~(rd_ph | (wr_ph & m[0]));
  assign ub_d   = ~(rd_ph | (wr_ph & m[1]));
  assign sa_d   = (rd_ph | wr_ph) ? 18'({word_d, hi}) : '0;
  assign dq_d   = hi ? wdata_d[31:16] : wdata_d[15:0];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      bmask_q <= '0;
      rdata_q <= '0;
      lo_q    <= '0;
      ack_q   <= 1'b0;
      sa_q    <= '0;
      ce_q    <= 1'b1;
      we_q    <= 1'b1;
      oe_q    <= 1'b1;
      lb_q    <= 1'b1;
      ub_q    <= 1'b1;
      dq_oe_q <= 1'b0;
      dq_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      bmask_q <= bmask_d;
      rdata_q <= rdata_d;
      lo_q    <= lo_d;
      ack_q   <= state_d == DONE;
      sa_q    <= sa_d;
      ce_q    <= ce_d;
      we_q    <= we_d;
      oe_q    <= oe_d;
      lb_q    <= lb_d;
      ub_q    <= ub_d;
      dq_oe_q <= wr_ph;
      dq_q    <= dq_d;
    end
  end
  assign bus.r_data = rdata_q;
  assign bus.ack    = ack_q;
  assign SRAM_ADDR  = sa_q;
  assign SRAM_CE_N  = ce_q;
  assign SRAM_WE_N  = we_q;
  assign SRAM_OE_N  = oe_q;
  assign SRAM_LB_N  = lb_q;
  assign SRAM_UB_N  = ub_q;
  assign SRAM_DQ    = dq_oe_q ? dq_q : 16'hzzzz;
endmodule

// File: tb/tb_sram_32b_responder.sv
// tb_sram_32b_responder: directed requests against a behavioural SRAM; an ack monitor checks a queue of expected responses.
module tb_sram_32b_responder;
  localparam int AW = 13;
  localparam int PC = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  sram_32b_responder_if #(.ADDR_W(AW)) bus ();
  wire  [15:0] dq;
  logic [17:0] sa;
  logic ce, we, oe, lb, ub;
  sram_32b_responder #(.ADDR_W(AW), .PHASE_CYC(PC)) dut (
    .clk(clk), .rst(rst), .bus(bus), .SRAM_ADDR(sa), .SRAM_DQ(dq),
    .SRAM_CE_N(ce), .SRAM_WE_N(we), .SRAM_OE_N(oe), .SRAM_LB_N(lb), .SRAM_UB_N(ub));
  logic [15:0] mem [0:4095];
  assign dq = (!ce && !oe && we) ? mem[sa[11:0]] : 16'hzzzz;
  always @(posedge clk) if (!ce && !we) begin
    if (!lb) mem[sa[11:0]][7:0]  <= dq[7:0];
    if (!ub) mem[sa[11:0]][15:8] <= dq[15:8];
  end
  int n_chk = 0;
  int n_fail = 0;
  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at edge %0d", name, act, exp, edge_n);
    end
  endtask
  typedef struct { int at; logic [31:0] rdata; } exp_t;
  exp_t q[$];
  exp_t mon_e;
  logic prev_ack = 1'b0;
  logic [31:0] last_rd = '0;
  always @(negedge clk) begin
    if (!rst) last_rd = '0;
    else if (bus.ack) begin
      chk("ack_width", 32'(prev_ack), 0);
      if (q.size() == 0) chk("unexpected_ack", 1, 0);
      else begin
        mon_e = q.pop_front();
        chk("ack_cycle", edge_n, mon_e.at);
        chk("r_data", bus.r_data, mon_e.rdata);
        last_rd = mon_e.rdata;
      end
    end else chk("r_data_hold", bus.r_data, last_rd);
    prev_ack = rst && bus.ack;
  end
  task automatic req(input logic wr, input logic rd, input logic [AW-1:0] a, input logic [31:0] d,
                     input logic [3:0] m, input logic [31:0] exp_rd);
    int np, lat, t;
    logic hs [2];
    logic h, lst;
    np = 2; hs[0] = 1'b0; hs[1] = 1'b1;
`ifdef SRAM_HALF_SKIP_EN
    if (wr) begin
      np = 0;
      if (|m[1:0]) begin hs[np] = 1'b0; np++; end
      if (|m[3:2]) begin hs[np] = 1'b1; np++; end
    end
`endif
    @(negedge clk);
    bus.wr_en = wr; bus.rd_en = rd; bus.addr = a; bus.w_data = d; bus.bmask = m;
    lat = 1 + np * PC;
    t = edge_n + 1;
    q.push_back('{t + lat - 1, exp_rd});
    for (int k = 0; k <= np * PC; k++) begin
      @(negedge clk);
      if (k == 0) begin bus.wr_en = 1'b0; bus.rd_en = 1'b0; end
      if (k < np * PC) begin
        h = hs[k / PC];
        lst = (k % PC) == PC - 1;
        chk("sram_addr", 32'(sa), 32'({a[AW-1:2], h}));
        chk("ctl", 32'({ce, oe, we, lb, ub}),
            32'({1'b0, wr, ~(wr & ~lst), wr & ~m[{h, 1'b0}], wr & ~m[{h, 1'b1}]}));
        if (wr) chk("dq_out", 32'(dq), 32'(h ? d[31:16] : d[15:0]));
      end else chk("done_ctl", 32'({ce, oe, we, lb, ub}), 32'h1f);
    end
    @(negedge clk);
    chk("sb_drained", q.size(), 0);
    q.delete();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = '0; bus.w_data = '0; bus.bmask = '0;
    repeat (2) @(negedge clk);
    chk("rst_ctl", 32'({ce, oe, we, lb, ub}), 32'h1f);
    chk("rst_addr", 32'(sa), 0);
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_rdata", bus.r_data, 0);
    rst = 1'b1;
    req(1, 0, 13'h0010, 32'hDEADBEEF, 4'hF, 32'h0);
    chk("mem8", 32'(mem[8]), 32'hBEEF);
    chk("mem9", 32'(mem[9]), 32'hDEAD);
    req(0, 1, 13'h0010, 32'h0, 4'h0, 32'hDEADBEEF);
    req(1, 0, 13'h0010, 32'h00005500, 4'h2, 32'hDEADBEEF);
    req(0, 1, 13'h0010, 32'h0, 4'h0, 32'hDEAD55EF);
    req(1, 1, 13'h0020, 32'h12345678, 4'hF, 32'hDEAD55EF);
    req(0, 1, 13'h0020, 32'h0, 4'h0, 32'h12345678);
    @(negedge clk);
    bus.rd_en = 1'b1; bus.addr = 13'h0020;
    repeat (3) @(negedge clk);
    bus.rd_en = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_ctl", 32'({ce, oe, we, lb, ub}), 32'h1f);
    chk("abort_addr", 32'(sa), 0);
    chk("abort_ack", 32'(bus.ack), 0);
    chk("abort_rdata", bus.r_data, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    req(0, 1, 13'h0010, 32'h0, 4'h0, 32'hDEAD55EF);
    fork
      req(0, 1, 13'h0020, 32'h0, 4'h0, 32'h12345678);
      begin
        repeat (2) @(negedge clk);
        #1 bus.rd_en = 1'b1; bus.addr = 13'h0010;
        @(negedge clk);
        #1 bus.rd_en = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    req(1, 0, 13'h0010, 32'hA5A50000, 4'hC, 32'h12345678);
    chk("mem9_hi", 32'(mem[9]), 32'hA5A5);
    req(1, 0, 13'h0010, 32'hFFFFFFFF, 4'h0, 32'h12345678);
    req(0, 1, 13'h0010, 32'h0, 4'h0, 32'hA5A555EF);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
